// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter that funnels N_REQ byte streams into one UART transmitter,
// optionally prefixing each message with a tag byte (TAG_BASE | owner index).
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req_data/valid/last    per-requester byte stream (requester i on req_data[8i+7:8i])
//   req_ready              per-requester accept (only the current owner, only in PASS)
//   tx_data/valid, tx_ready  byte stream towards the UART transmitter
//   grant_id               current owner; holds the previous owner while idle
//   busy                   high whenever a message is in progress (TAG or PASS)
//   trunc_err              one-cycle pulse after a message is cut at MAX_LEN bytes
module uart_tx_arb #(
    parameter int          N_REQ    = 4,
    parameter bit          TAG_EN   = 1'b1,
    parameter logic [7:0]  TAG_BASE = 8'hA0,
    parameter int          MAX_LEN  = 64,
    localparam int         GW       = $clog2(N_REQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ*8-1:0] req_data,
    input  logic [N_REQ-1:0]  req_valid,
    input  logic [N_REQ-1:0]  req_last,
    output logic [N_REQ-1:0]  req_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [GW-1:0]     grant_id,
    output logic              busy,
    output logic              trunc_err
);
    typedef enum logic [1:0] {IDLE, TAG, PASS} state_t;
    state_t state, state_nx;
    logic [GW-1:0] last_owner, winner, idx;
    logic [7:0] len;
    logic accept, at_max, done;
    // Scan downward so the nearest requester after last_owner is written last and wins.
    always_comb begin
        winner = '0;
        idx = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = GW'((int'(last_owner) + k) % N_REQ);
            if (req_valid[idx]) winner = idx;
        end
    end
    assign accept = state == PASS && req_valid[grant_id] && tx_ready;
    assign at_max = len == 8'(MAX_LEN - 1);
    assign done   = accept && (req_last[grant_id] || at_max);
    assign busy   = state != IDLE;
    always_comb begin
        state_nx  = state;
        tx_valid  = 1'b0;
        tx_data   = '0;
        req_ready = '0;
        unique case (state)
            IDLE: if (|req_valid) state_nx = TAG_EN ? TAG : PASS;
            TAG: begin
                tx_valid = 1'b1;
                tx_data  = TAG_BASE | 8'(grant_id);
                if (tx_ready) state_nx = PASS;
            end
            PASS: begin
                tx_valid            = req_valid[grant_id];
                tx_data             = req_data[8*grant_id +: 8];
                req_ready[grant_id] = tx_ready;
                if (done) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        state <= !rst_n ? IDLE : state_nx;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_id   <= '0;
            last_owner <= GW'(N_REQ - 1);
            len        <= '0;
            trunc_err  <= 1'b0;
        end else begin
            // A message ending without req_last can only be a cut at MAX_LEN.
            trunc_err <= done && !req_last[grant_id];
            if (state == IDLE && |req_valid) grant_id <= winner;
            if (state_nx == PASS && state != PASS) len <= '0;
            else if (accept) len <= len + 8'd1;
            if (done) last_owner <= grant_id;
        end
    end
endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters (2..8).
REQ-002 Parameter TAG_EN, default 1: when 1, a tag byte is inserted before each message.
REQ-003 Parameter TAG_BASE, default 8'hA0: tag byte value is TAG_BASE OR granted index.
REQ-004 Parameter MAX_LEN, default 64: maximum payload bytes per message (2..255).
REQ-005 clk  input  1  clock; all logic is rising-edge.
REQ-006 rst_n  input  1  reset; asynchronous, active-low.
REQ-007 req_data  input  N_REQ*8  payload bytes; requester i occupies bits [8i+7:8i].
REQ-008 req_valid  input  N_REQ  per-requester byte valid.
REQ-009 req_last  input  N_REQ  per-requester last byte of message, qualified by req_valid.
REQ-010 req_ready  output  N_REQ  per-requester byte accepted when req_valid and req_ready are both high.
REQ-011 tx_data  output  8  byte to the UART transmitter.
REQ-012 tx_valid  output  1  tx_data is valid.
REQ-013 tx_ready  input  1  UART transmitter accepts a byte (the UART transmitter's data_ready).
REQ-014 grant_id  output  $clog2(N_REQ)  index of the current owner; holds the last owner when idle.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 trunc_err  output  1  one-cycle pulse when a message is cut at MAX_LEN.

Function
REQ-017 The FSM SHALL have three states: IDLE, TAG and PASS.
REQ-018 IDLE: tx_valid=0 and req_ready=0; on any req_valid, latch the winner into grant_id and move to TAG (TAG_EN=1) or PASS (TAG_EN=0) on the next edge; first tx_valid appears one cycle after req_valid.
REQ-019 Arbitration SHALL be round-robin: search from (last owner + 1) mod N_REQ upward with wrap; the first asserted req_valid wins.
REQ-020 TAG: tx_valid=1, tx_data=TAG_BASE|grant_id, all req_ready=0; on tx_ready move to PASS.
REQ-021 PASS: combinational path tx_valid=req_valid[g], tx_data=req_data[g], req_ready[g]=tx_ready, with all other req_ready bits 0 (g = grant_id).
REQ-022 Ownership SHALL be held through PASS even if req_valid[g] drops; other requesters are ignored until the message ends.
REQ-023 A message SHALL end on the accepted byte with req_last[g]=1; the FSM returns to IDLE and the last owner is updated to g.
REQ-024 An 8-bit length counter SHALL clear on entry to PASS and increment per accepted payload byte.
REQ-025 If the accepted byte is payload byte number MAX_LEN and req_last[g]=0, the FSM SHALL end the message as in REQ-023 and pulse trunc_err for one cycle.
REQ-026 After truncation, the requester's remaining bytes SHALL be treated as a new message that competes normally.
REQ-027 A single-byte message (req_last on the first byte) SHALL be legal and take TAG plus one PASS transfer.
REQ-028 IDLE->grant and message end SHALL never overlap: a minimum of one IDLE cycle separates consecutive messages.
REQ-029 tx_data and tx_valid SHALL remain stable while tx_valid=1 and tx_ready=0 in TAG; in PASS, stability follows the requester's own obligation.

Reset
REQ-030 While rst_n=0: state=IDLE, tx_valid=0, req_ready=0, busy=0, trunc_err=0, grant_id=0, length counter=0, last-owner pointer=N_REQ-1 so that requester 0 has first priority.
REQ-031 Reset asserted mid-message SHALL abandon the message immediately; no completion and no trunc_err are generated.
REQ-032 After release, the first arbitration SHALL follow REQ-030 priority.

Verification
REQ-033 Reset, then req_valid=4'b1010 with a 2-byte message each -> tag 8'hA1, 2 bytes from requester 1, at least one IDLE cycle, tag 8'hA3, 2 bytes from requester 3.
REQ-034 All four requesters send continuously -> tags cycle A0, A1, A2, A3, A0 with no requester starved.
REQ-035 tx_ready held low for 100 cycles during TAG -> tx_data=8'hA2 and tx_valid=1 held stable; all req_ready bits stay 0.
REQ-036 Requester 0 sends 70 bytes with no req_last, MAX_LEN=64 -> trunc_err pulses on byte 64; the remaining 6 bytes follow under a new tag once requester 0 wins again.
REQ-037 Requester 2 drops req_valid mid-message while requester 1 is valid -> grant_id stays 2 and req_ready[1]=0 until requester 2's req_last is accepted.
REQ-038 rst_n pulsed low during PASS byte 3 -> tx_valid=0 and busy=0 asynchronously; the next message starts with a tag.
